// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between ports A and B, one access in flight.
// Grant >=1 cycle after req, read data READ_LAT cycles after grant; losers and in-flight owners see *_stall.
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          a_stall,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          b_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_nxt;
    logic          owner;          // 0 = port A, 1 = port B
    logic          last_grant;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    cnt, cnt_nxt;
    logic [DW-1:0] a_rdata_q, b_rdata_q;
    logic          sel_b, load, issue, data_cyc;

    // B wins when it is alone, or when both ask and A was served last.
    assign sel_b = b_req & (~a_req | ~last_grant);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 3'(READ_LAT);
                end
            end
            WAIT: begin
                if (cnt <= 3'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                owner      <= sel_b;
                last_grant <= sel_b;
                lat_we     <= sel_b ? b_we    : a_we;
                lat_addr   <= sel_b ? b_addr  : a_addr;
                lat_wdata  <= sel_b ? b_wdata : a_wdata;
            end
            if (a_rvalid) a_rdata_q <= mem_rdata;
            if (b_rvalid) b_rdata_q <= mem_rdata;
        end
    end

    assign issue    = (state == ISSUE);
    assign data_cyc = (state == WAIT) && (cnt <= 3'd1);

    assign mem_en    = issue;
    assign mem_we    = issue & lat_we;
    assign mem_addr  = issue ? lat_addr  : '0;
    assign mem_wdata = issue ? lat_wdata : '0;
    assign busy      = (state != IDLE);

    assign a_gnt    = issue & ~owner;
    assign b_gnt    = issue & owner;
    assign a_rvalid = data_cyc & ~owner;
    assign b_rvalid = data_cyc & owner;

    // Read data is passed straight through in the data cycle and held afterwards.
    assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
    assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;

    // Stall is gated by reset so every output reads 0 while reset is held.
    assign a_stall = rst & a_req & ~(a_gnt & a_we) & ~a_rvalid;
    assign b_stall = rst & b_req & ~(b_gnt & b_we) & ~b_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random transactions against a transaction-level reference.
module tb_mem_port_arbiter;
    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int READ_LAT = 2;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_gnt, a_rvalid, a_stall;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid, b_stall;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_stall(b_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return (a == 16'h0100) ? 32'h12345678 : {~a, a};
    endfunction

    // RAM model: 2-cycle read pipeline, garbage on mem_rdata when no read is returning.
    logic [31:0] mem_store [logic [15:0]];
    logic [31:0] rd0, rd1;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_store[mem_addr] = mem_wdata;
        if (mem_en && !mem_we)
            rd0 <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
        else
            rd0 <= $urandom;
        rd1 <= rd0;
    end
    assign mem_rdata = rd1;

    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] ref_mem [logic [15:0]];
    bit          ref_last_b;
    logic [31:0] last_a, last_b;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction group: optional A access at cycle 0, optional B access raised at cycle b_dly.
    task automatic run_txn(input bit ra, input bit wa, input logic [15:0] aa, input logic [31:0] da,
                           input bit rb, input bit wb, input logic [15:0] ab, input logic [31:0] db,
                           input int b_dly);
        bit          pa, pb, wt_a, wt_b, b_up, exp_b, g_we, done;
        int          free_cyc, rise_a, rise_b, gc_a, gc_b, rise, exp_cyc;
        logic [15:0] g_addr;
        logic [31:0] g_dat, ea, eb;
        b_up = !rb || (b_dly == 0);
        pa = ra; pb = rb && (b_dly == 0);
        wt_a = 0; wt_b = 0; done = 0;
        free_cyc = 1; rise_a = 0; rise_b = 0; gc_a = 0; gc_b = 0;
        ea = '0; eb = '0;
        a_req = pa; a_we = wa; a_addr = aa; a_wdata = da;
        b_req = pb; b_we = wb; b_addr = ab; b_wdata = db;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            check("a_stall", 64'(a_stall), 64'(pa && !(a_gnt && wa)));
            check("b_stall", 64'(b_stall), 64'(pb && !(b_gnt && wb)));
            check("gnt_exclusive", 64'(a_gnt && b_gnt), 64'(0));
            if (a_gnt || b_gnt) begin
                check("gnt_without_req", 64'(pa || pb), 64'(1));
                if (pa && pb) exp_b = !ref_last_b;
                else          exp_b = pb;
                check("gnt_owner_is_b", 64'(b_gnt), 64'(exp_b));
                rise    = b_gnt ? rise_b : rise_a;
                exp_cyc = (rise + 1 > free_cyc) ? rise + 1 : free_cyc;
                check("gnt_cycle", 64'(cyc), 64'(exp_cyc));
                g_we   = b_gnt ? wb : wa;
                g_addr = b_gnt ? ab : aa;
                g_dat  = b_gnt ? db : da;
                check("mem_en", 64'(mem_en), 64'(1));
                check("mem_we", 64'(mem_we), 64'(g_we));
                check("mem_addr", 64'(mem_addr), 64'(g_addr));
                check("busy_issue", 64'(busy), 64'(1));
                if (g_we) begin
                    check("mem_wdata", 64'(mem_wdata), 64'(g_dat));
                    ref_mem[g_addr] = g_dat;
                end else if (b_gnt) begin
                    wt_b = 1; eb = ref_rd(g_addr); gc_b = cyc;
                end else begin
                    wt_a = 1; ea = ref_rd(g_addr); gc_a = cyc;
                end
                free_cyc   = cyc + (g_we ? 2 : READ_LAT + 2);
                ref_last_b = b_gnt;
                if (b_gnt) begin
                    pb = 0; b_req = 0; b_addr = 16'($urandom); b_wdata = $urandom;
                end else begin
                    pa = 0; a_req = 0; a_addr = 16'($urandom); a_wdata = $urandom;
                end
            end else begin
                check("mem_en_quiet", 64'(mem_en), 64'(0));
            end
            if (a_rvalid) begin
                check("a_rvalid_expected", 64'(wt_a), 64'(1));
                check("a_read_latency", 64'(cyc - gc_a), 64'(READ_LAT));
                check("a_rdata", 64'(a_rdata), 64'(ea));
                wt_a = 0; last_a = ea;
            end
            if (b_rvalid) begin
                check("b_rvalid_expected", 64'(wt_b), 64'(1));
                check("b_read_latency", 64'(cyc - gc_b), 64'(READ_LAT));
                check("b_rdata", 64'(b_rdata), 64'(eb));
                wt_b = 0; last_b = eb;
            end
            if (!b_up && cyc == b_dly) begin
                b_up = 1; pb = 1; b_req = 1; rise_b = cyc;
            end
            done = b_up && !pa && !pb && !wt_a && !wt_b;
            if (done) break;
        end
        check("txn_completed", 64'(done), 64'(1));
        a_req = 0; b_req = 0;
        @(posedge clk); #1;
        check("busy_after", 64'(busy), 64'(0));
        check("a_rdata_held", 64'(a_rdata), 64'(last_a));
        check("b_rdata_held", 64'(b_rdata), 64'(last_b));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ra, rb, wa, wb;
        logic [15:0] aa, ab;
        int          dly;
        rst = 0; last_a = '0; last_b = '0; ref_last_b = 1;
        a_req = 1; a_we = 0; a_addr = 16'h0040; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_a_gnt", 64'(a_gnt), 64'(0));
        check("rst_b_gnt", 64'(b_gnt), 64'(0));
        check("rst_a_rvalid", 64'(a_rvalid), 64'(0));
        check("rst_a_rdata", 64'(a_rdata), 64'(0));
        check("rst_a_stall", 64'(a_stall), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1;
        run_txn(1, 0, 16'h0040, 32'h0, 0, 0, 16'h0, 32'h0, 0);
        run_txn(1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0, 0);
        run_txn(0, 0, 16'h0, 32'h0, 1, 0, 16'h0100, 32'h0, 0);
        // B arrives while A's read is in WAIT
        run_txn(1, 0, 16'h0010, 32'h0, 1, 0, 16'h0100, 32'h0, 2);

        // reset during a read: no data ever returned for it
        a_req = 1; a_we = 0; a_addr = 16'h0200;
        @(posedge clk); #1;
        check("midrst_gnt", 64'(a_gnt), 64'(1));
        a_req = 0;
        @(posedge clk); #1;
        rst = 0; #1;
        check("midrst_mem_en", 64'(mem_en), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_a_rvalid", 64'(a_rvalid), 64'(0));
        @(posedge clk); #1;
        rst = 1; ref_last_b = 1; last_a = '0; last_b = '0;
        repeat (4) begin
            @(posedge clk); #1;
            check("postrst_no_a_rvalid", 64'(a_rvalid), 64'(0));
            check("postrst_no_b_rvalid", 64'(b_rvalid), 64'(0));
        end
        run_txn(1, 0, 16'h0010, 32'h0, 1, 0, 16'h0100, 32'h0, 0);
        run_txn(1, 1, 16'h0020, 32'hA5A5A5A5, 1, 1, 16'h0030, 32'h5A5A5A5A, 0);
        run_txn(1, 0, 16'h0030, 32'h0, 1, 0, 16'h0020, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = 1'($urandom_range(0, 1));
            rb  = ra ? 1'($urandom_range(0, 1)) : 1'b1;
            wa  = 1'($urandom_range(0, 1));
            wb  = 1'($urandom_range(0, 1));
            aa  = 16'($urandom_range(0, 7)) << 4;
            ab  = 16'($urandom_range(0, 7)) << 4;
            dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_txn(ra, wa, aa, $urandom, rb, wb, ab, $urandom, dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
